// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch-stage widths, constants and the buffered fetch entry type
package rv_fetch_pkg;
   localparam int XLEN = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flushable synchronous FIFO of fetch entries; head is read straight from storage
module fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  din,
   output fetch_entry_t  dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] CAP = CW'(DEPTH);
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   assign dout = mem[rd_ptr];
   assign empty = count == '0;
   assign full = count == CAP;
   // Storage and pointers; flush drops every entry but leaves stored words untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) mem[wr_ptr] <= din;
         wr_ptr <= push ? ((wr_ptr == LAST) ? '0 : wr_ptr + AW'(1)) : wr_ptr;
         rd_ptr <= pop ? ((rd_ptr == LAST) ? '0 : rd_ptr + AW'(1)) : rd_ptr;
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: in-order PC fetch with credit-limited memory requests and a flushable decode buffer
module instruction_fetch
   import rv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction_code,
   output logic [31:0] instr_pc
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);
   localparam logic [CW:0] CAP = (CW + 1)'(FIFO_DEPTH);
   logic [XLEN-1:0] pc, rsp_pc, redirect_base;
   logic [CW-1:0] outstanding, drop_cnt, fifo_count;
   logic fifo_full, fifo_empty, req_fire, rsp_keep, rsp_drop, pop, credit;
   fetch_entry_t entry, head;
   assign redirect_base = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
   assign pop = instr_valid && instr_ready;
   // A slot being popped this cycle is free by the time any new response can land, which keeps
   // one fetch per cycle with a 1-cycle memory; the credit it grants is still held next cycle.
   assign credit = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CAP + {{CW{1'b0}}, pop});
   assign imem_req_valid = !reset && !redirect_valid && drop_cnt == '0 && credit;
   assign imem_req_addr = pc;
   assign req_fire = imem_req_valid && imem_req_ready;
   assign rsp_keep = imem_rsp_valid && !redirect_valid && drop_cnt == '0;
   assign rsp_drop = imem_rsp_valid && !redirect_valid && drop_cnt != '0;
   assign instr_valid = !fifo_empty && !redirect_valid;
   assign entry = '{pc: rsp_pc, instr: imem_rsp_data};
   assign instruction_code = head.instr;
   assign instr_pc = head.pc;
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rsp_keep),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (entry),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
   // Fetch/response PCs and in-flight bookkeeping; a redirect marks everything still in flight as stale
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
         rsp_pc <= RESET_PC;
         outstanding <= '0;
         drop_cnt <= '0;
      end else begin
         pc <= redirect_valid ? redirect_base : req_fire ? pc + STEP : pc;
         rsp_pc <= redirect_valid ? redirect_base : rsp_keep ? rsp_pc + STEP : rsp_pc;
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
         drop_cnt <= redirect_valid ? outstanding - CW'(imem_rsp_valid) : drop_cnt - CW'(rsp_drop);
      end
   end
   // A kept response always finds a free slot because requests are issued only against credit
   assert property (@(posedge clk) disable iff (reset) !(rsp_keep && fifo_full && !pop));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed cycle checks plus an in-order scoreboard against a variable-latency memory model
module tb_instruction_fetch;
   localparam logic [31:0] RPC = 32'h0000_0100;
   logic clk = 1'b0, reset = 1'b1, redirect_valid = 1'b0, imem_req_ready = 1'b1;
   logic imem_rsp_valid = 1'b0, instr_ready = 1'b1;
   logic imem_req_valid, instr_valid;
   logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
   logic [31:0] imem_req_addr, instruction_code, instr_pc;
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1, stall = 0;
   int pops = 0, rsps = 0, acc = 0, p0 = 0, a0 = 0, due = 0;
   bit rand_mode = 1'b0;
   int q_due[$];
   logic [31:0] q_addr[$];
   logic [31:0] exp_pc = RPC, exp_req = RPC;
   bit t3_req[7] = '{0, 0, 1, 1, 0, 0, 1};
   bit t3_iv[7] = '{0, 0, 0, 0, 0, 0, 1};
   bit t4_iv[3] = '{0, 0, 1};

   instruction_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instruction_code (instruction_code),
      .instr_pc         (instr_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      step();
      sample();
      check("rst_req_valid", 32'(imem_req_valid), 0);
      check("rst_instr_valid", 32'(instr_valid), 0);
      check("rst_req_addr", imem_req_addr, RPC);
      check("rst_instr_code", instruction_code, 0);
      check("rst_instr_pc", instr_pc, 0);
      step();
      reset = 1'b0;
   endtask

   // Memory model and scoreboard: sample handshakes mid-cycle, drive responses just after the edge
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            q_due.delete();
            q_addr.delete();
            last_due = 0;
            exp_pc = RPC;
            exp_req = RPC;
            pops = 0;
            rsps = 0;
            acc = 0;
         end else begin
            if (imem_rsp_valid) rsps++;
            if (redirect_valid) begin
               check("redirect_req_valid", 32'(imem_req_valid), 0);
               check("redirect_instr_valid", 32'(instr_valid), 0);
               exp_pc = {redirect_pc[31:2], 2'b00};
               exp_req = exp_pc;
            end else begin
               if (imem_req_valid && imem_req_ready) begin
                  check("req_addr", imem_req_addr, exp_req);
                  exp_req += 32'd4;
                  acc++;
                  due = cyc + int'($urandom_range(lat_max, lat_min));
                  if (due <= last_due) due = last_due + 1;
                  last_due = due;
                  q_due.push_back(due);
                  q_addr.push_back(imem_req_addr);
                  if (rand_mode) stall = int'($urandom_range(3, 0));
               end
               if (instr_valid && instr_ready) begin
                  check("sb_pc", instr_pc, exp_pc);
                  check("sb_instr", instruction_code, mem_word(exp_pc));
                  exp_pc += 32'd4;
                  pops++;
               end
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         imem_rsp_valid = 1'b0;
         if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mem_word(q_addr[0]);
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
         end
         imem_req_ready = !(stall > 0);
         if (stall > 0) stall--;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      // reset values, then streaming from RESET_PC with a 1-cycle memory
      do_reset();
      sample();
      check("t1_c0_iv", 32'(instr_valid), 0);
      check("t1_c0_req", 32'(imem_req_valid), 1);
      check("t1_c0_addr", imem_req_addr, RPC);
      step();
      sample();
      check("t1_c1_iv", 32'(instr_valid), 0);
      check("t1_c1_req", 32'(imem_req_valid), 1);
      check("t1_c1_addr", imem_req_addr, RPC + 32'd4);
      step();
      sample();
      check("t1_c2_iv", 32'(instr_valid), 1);
      check("t1_c2_pc", instr_pc, RPC);
      check("t1_c2_code", instruction_code, mem_word(RPC));
      step();
      p0 = pops;
      repeat (8) step();
      check("t1_rate", 32'(pops - p0), 8);
      // decode stalls for 10 cycles: buffer fills, requests stop, nothing lost afterwards
      instr_ready = 1'b0;
      a0 = acc;
      repeat (9) step();
      sample();
      check("t2_req_valid", 32'(imem_req_valid), 0);
      check("t2_instr_valid", 32'(instr_valid), 1);
      check("t2_no_new_req", 32'(acc - a0), 0);
      check("t2_held", 32'(rsps - pops + q_due.size()), 2);
      step();
      instr_ready = 1'b1;
      p0 = pops;
      repeat (10) step();
      check("t2_drain_rate", 32'(pops - p0), 10);
      // redirect to a misaligned PC while two 3-cycle requests are in flight
      lat_min = 3;
      lat_max = 3;
      do_reset();
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_2003;
      sample();
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         sample();
         check($sformatf("t3_req_c%0d", i + 3), 32'(imem_req_valid), 32'(t3_req[i]));
         check($sformatf("t3_iv_c%0d", i + 3), 32'(instr_valid), 32'(t3_iv[i]));
         if (i == 2) check("t3_addr", imem_req_addr, 32'h0000_2000);
         if (i == 6) check("t3_pc", instr_pc, 32'h0000_2000);
         step();
      end
      // redirect coinciding with a response and a ready decode
      lat_min = 1;
      lat_max = 1;
      do_reset();
      repeat (5) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_3000;
      p0 = pops;
      sample();
      check("t4_no_pop", 32'(pops - p0), 0);
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         check($sformatf("t4_req_c%0d", i), 32'(imem_req_valid), 1);
         check($sformatf("t4_iv_c%0d", i), 32'(instr_valid), 32'(t4_iv[i]));
         if (i == 0) check("t4_addr", imem_req_addr, 32'h0000_3000);
         if (i == 2) check("t4_pc", instr_pc, 32'h0000_3000);
         step();
      end
      // random request stalls, response latency 1..3, random decode ready, periodic redirects
      rand_mode = 1'b1;
      lat_max = 3;
      p0 = pops;
      for (int i = 0; i < 400; i++) begin
         instr_ready = $urandom_range(3, 0) != 0;
         redirect_valid = (i % 97) == 50;
         redirect_pc = 32'h0000_4000 + 32'(i * 16) + 32'd3;
         step();
      end
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      check("t5_progress", 32'(pops - p0 >= 40), 1);
      rand_mode = 1'b0;
      repeat (10) step();
      // PC wrap at the top of the address space, then reset mid-stream
      lat_max = 1;
      do_reset();
      repeat (3) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      sample();
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample();
         if (i < 3) check($sformatf("t6_addr%0d", i), imem_req_addr, 32'hFFFF_FFF8 + 32'(4 * i));
         if (i >= 2) check($sformatf("t6_pc%0d", i), instr_pc, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
         step();
      end
      do_reset();
      step();
      step();
      sample();
      check("t6_restart_iv", 32'(instr_valid), 1);
      check("t6_restart_pc", instr_pc, RPC);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
